// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element datapath.
//   acc_bits()        : accumulator width needed for I_BITS operands over K_MAX beats
//   sat_max/sat_min() : signed limits of an o_bits-wide result
//   round_shift_sat() : round-half-up right shift followed by saturation, returns {sat, y}
package pe_pkg;

  // Working width of the generic rounding helper; any accumulator up to RsW bits fits.
  localparam int unsigned RsW = 64;

  // Limits for the default 16-bit result width.
  localparam int unsigned OBitsDef = 16;
  localparam logic signed [OBitsDef-1:0] OMaxDef = {1'b0, {(OBitsDef - 1){1'b1}}};
  localparam logic signed [OBitsDef-1:0] OMinDef = {1'b1, {(OBitsDef - 1){1'b0}}};

  typedef struct packed {
    logic              sat;
    logic signed [RsW-1:0] y;
  } rs_t;

  function automatic int unsigned acc_bits(input int unsigned i_bits, input int unsigned k_max);
    return 2 * i_bits + $clog2(k_max);
  endfunction

  function automatic logic signed [RsW:0] sat_max(input int unsigned o_bits);
    return ((RsW + 1)'(1) << (o_bits - 1)) - (RsW + 1)'(1);
  endfunction

  function automatic logic signed [RsW:0] sat_min(input int unsigned o_bits);
    // Two's complement: -max-1 == ~max.
    return ~sat_max(o_bits);
  endfunction

  function automatic rs_t round_shift_sat(input logic signed [RsW-1:0] acc,
                                          input int unsigned          shift,
                                          input int unsigned          o_bits);
    logic signed [RsW:0] wide;
    logic signed [RsW:0] half;
    logic signed [RsW:0] hi;
    logic signed [RsW:0] lo;
    rs_t                 r;
    // One guard bit so adding the rounding constant can never wrap.
    wide = {acc[RsW-1], acc};
    if (shift != 0) begin
      half = (RsW + 1)'(1) << (shift - 1);
      wide = (wide + half) >>> shift;
    end
    hi    = sat_max(o_bits);
    lo    = sat_min(o_bits);
    r.sat = 1'b0;
    r.y   = wide[RsW-1:0];
    if (wide > hi) begin
      r.sat = 1'b1;
      r.y   = hi[RsW-1:0];
    end else if (wide < lo) begin
      r.sat = 1'b1;
      r.y   = lo[RsW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_round_sat.sv
// Combinational round-shift-saturate stage.
//   acc_i   : signed accumulator value
//   shift_i : right-shift amount (round half up)
//   y_o     : signed, saturated O_BITS result
//   sat_o   : y_o was clipped to min/max
module pe_round_sat
  import pe_pkg::*;
#(
  parameter int unsigned ACC_BITS   = 20,
  parameter int unsigned O_BITS     = 16,
  parameter int unsigned SHIFT_BITS = 5
) (
  input  logic signed [ACC_BITS-1:0]   acc_i,
  input  logic        [SHIFT_BITS-1:0] shift_i,
  output logic signed [O_BITS-1:0]     y_o,
  output logic                         sat_o
);

  rs_t  res;
  logic unused_y;

  always_comb begin
    res = round_shift_sat({{(RsW - ACC_BITS){acc_i[ACC_BITS-1]}}, acc_i}, 32'(shift_i), O_BITS);
  end

  assign y_o      = res.y[O_BITS-1:0];
  assign sat_o    = res.sat;
  // Upper bits are pure sign extension once saturated.
  assign unused_y = ^res.y[RsW-1:O_BITS];

endmodule

// File: rtl/pe_mac_rs.sv
// Systolic processing element: valid-qualified signed MAC over a programmable length.
//   i_clock, i_reset        : clock, synchronous active-low reset
//   i_k_len, i_shift        : dot-product length and output shift, latched on a start beat
//   i_a/i_a_valid, i_b/...  : operands from left / above
//   i_start                 : first beat of a new dot product (only when both valids high)
//   o_a*, o_b*, o_start     : one-cycle registered forwards of the inputs
//   o_c, o_c_valid, o_sat   : rounded/saturated result, one-cycle pulse, saturation flag
//   o_err                   : sticky framing error
module pe_mac_rs
  import pe_pkg::*;
#(
  parameter int unsigned I_BITS     = 8,
  parameter int unsigned K_MAX      = 16,
  parameter int unsigned O_BITS     = 16,
  parameter int unsigned ACC_BITS   = acc_bits(I_BITS, K_MAX),
  parameter int unsigned K_BITS     = $clog2(K_MAX + 1),
  parameter int unsigned SHIFT_BITS = $clog2(ACC_BITS)
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [K_BITS-1:0]        i_k_len,
  input  logic [SHIFT_BITS-1:0]    i_shift,
  input  logic signed [I_BITS-1:0] i_a,
  input  logic                     i_a_valid,
  input  logic signed [I_BITS-1:0] i_b,
  input  logic                     i_b_valid,
  input  logic                     i_start,
  output logic signed [I_BITS-1:0] o_a,
  output logic                     o_a_valid,
  output logic signed [I_BITS-1:0] o_b,
  output logic                     o_b_valid,
  output logic                     o_start,
  output logic signed [O_BITS-1:0] o_c,
  output logic                     o_c_valid,
  output logic                     o_sat,
  output logic                     o_err
);

  typedef enum logic {StIdle, StAcc} state_e;

  state_e                     state_q, state_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [K_BITS-1:0]          count_q, count_d;
  logic [K_BITS-1:0]          klen_q, klen_d;
  logic [SHIFT_BITS-1:0]      shift_q, shift_d;
  logic                       err_q, err_d;
  logic signed [O_BITS-1:0]   c_q, c_d;
  logic                       c_valid_q, c_valid_d;
  logic                       sat_q, sat_d;

  logic signed [I_BITS-1:0]   a_q, b_q;
  logic                       a_valid_q, b_valid_q, start_q;

  logic                       fire;
  logic                       begin_new;
  logic                       done;
  logic signed [2*I_BITS-1:0] prod;
  logic signed [ACC_BITS-1:0] prod_ext;
  logic signed [ACC_BITS-1:0] acc_nxt;
  logic [K_BITS-1:0]          cnt_nxt;
  logic [K_BITS-1:0]          klen_nxt;
  logic [K_BITS-1:0]          klen_clamp;
  logic [SHIFT_BITS-1:0]      shift_nxt;
  logic signed [O_BITS-1:0]   rs_y;
  logic                       rs_sat;

  assign fire     = i_a_valid & i_b_valid;
  assign prod     = i_a * i_b;
  assign prod_ext = {{(ACC_BITS - 2 * I_BITS){prod[2*I_BITS-1]}}, prod};

  always_comb begin
    klen_clamp = i_k_len;
    if (i_k_len == '0) begin
      klen_clamp = K_BITS'(1);
    end else if (i_k_len > K_BITS'(K_MAX)) begin
      klen_clamp = K_BITS'(K_MAX);
    end
  end

  // Value the accumulator would take if this beat fires; a start beat restarts it.
  always_comb begin
    begin_new = (state_q == StIdle) | i_start;
    if (begin_new) begin
      acc_nxt   = prod_ext;
      cnt_nxt   = K_BITS'(1);
      klen_nxt  = klen_clamp;
      shift_nxt = i_shift;
    end else begin
      acc_nxt   = acc_q + prod_ext;
      cnt_nxt   = count_q + K_BITS'(1);
      klen_nxt  = klen_q;
      shift_nxt = shift_q;
    end
    done = fire & (cnt_nxt == klen_nxt);
  end

  // Rounding works on the next accumulator so the result lands one cycle after the last beat.
  pe_round_sat #(
    .ACC_BITS   (ACC_BITS),
    .O_BITS     (O_BITS),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_round_sat (
    .acc_i   (acc_nxt),
    .shift_i (shift_nxt),
    .y_o     (rs_y),
    .sat_o   (rs_sat)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    klen_d    = klen_q;
    shift_d   = shift_q;
    err_d     = err_q;
    c_d       = c_q;
    c_valid_d = 1'b0;
    sat_d     = 1'b0;
    if (fire) begin
      acc_d   = acc_nxt;
      klen_d  = klen_nxt;
      shift_d = shift_nxt;
      if (i_start && (state_q == StAcc)) begin
        err_d = 1'b1;
      end
      if (done) begin
        state_d   = StIdle;
        count_d   = '0;
        c_d       = rs_y;
        c_valid_d = 1'b1;
        sat_d     = rs_sat;
      end else begin
        state_d = StAcc;
        count_d = cnt_nxt;
      end
    end else if (i_a_valid ^ i_b_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      count_q   <= '0;
      klen_q    <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
      c_q       <= '0;
      c_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      b_q       <= '0;
      b_valid_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      klen_q    <= klen_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      sat_q     <= sat_d;
      a_q       <= i_a;
      a_valid_q <= i_a_valid;
      b_q       <= i_b;
      b_valid_q <= i_b_valid;
      start_q   <= i_start;
    end
  end

  assign o_a       = a_q;
  assign o_a_valid = a_valid_q;
  assign o_b       = b_q;
  assign o_b_valid = b_valid_q;
  assign o_start   = start_q;
  assign o_c       = c_q;
  assign o_c_valid = c_valid_q;
  assign o_sat     = sat_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_pe_mac_rs.sv
module tb_pe_mac_rs;

  localparam int unsigned IB = 8;
  localparam int unsigned KM = 16;
  localparam int unsigned OB = 16;
  localparam int unsigned KB = 5;
  localparam int unsigned SB = 5;

  logic                 clk = 1'b0;
  logic                 rst_drv;
  logic [KB-1:0]        k_drv;
  logic [SB-1:0]        sh_drv;
  logic signed [IB-1:0] a_drv, b_drv;
  logic                 av_drv, bv_drv, st_drv;

  logic signed [IB-1:0] o_a, o_b;
  logic                 o_av, o_bv, o_st;
  logic signed [OB-1:0] o_c;
  logic                 o_cv, o_sat, o_err;

  always #5 clk = ~clk;

  pe_mac_rs #(
    .I_BITS (IB),
    .K_MAX  (KM),
    .O_BITS (OB)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst_drv),
    .i_k_len   (k_drv),
    .i_shift   (sh_drv),
    .i_a       (a_drv),
    .i_a_valid (av_drv),
    .i_b       (b_drv),
    .i_b_valid (bv_drv),
    .i_start   (st_drv),
    .o_a       (o_a),
    .o_a_valid (o_av),
    .o_b       (o_b),
    .o_b_valid (o_bv),
    .o_start   (o_st),
    .o_c       (o_c),
    .o_c_valid (o_cv),
    .o_sat     (o_sat),
    .o_err     (o_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rst_next = 1'b1;

  typedef struct {
    int c;
    bit sat;
    int cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int k;
    int sh;
    int n;
    int a0;
    int da;
    int b0;
    int db;
    int c;
    bit s;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Drives one cycle of inputs; the DUT samples them at the next rising edge.
  task automatic beat(input bit av, input bit bv, input int a, input int b, input bit st,
                      input int k, input int sh);
    @(negedge clk);
    rst_drv = rst_next;
    av_drv  = av;
    bv_drv  = bv;
    a_drv   = IB'(a);
    b_drv   = IB'(b);
    st_drv  = st;
    k_drv   = KB'(k);
    sh_drv  = SB'(sh);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  // Called right after the last beat is driven: result is due one edge later.
  task automatic expect_now(input int c, input bit s);
    exp_t e;
    e.c   = c;
    e.sat = s;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: forwarding/reset checks every cycle, scoreboard pop on each result pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_drv) begin
        chk("rst o_a", o_a, 0);
        chk("rst o_b", o_b, 0);
        chk("rst o_a_valid", o_av, 0);
        chk("rst o_b_valid", o_bv, 0);
        chk("rst o_start", o_st, 0);
        chk("rst o_c", o_c, 0);
        chk("rst o_c_valid", o_cv, 0);
        chk("rst o_sat", o_sat, 0);
        chk("rst o_err", o_err, 0);
      end else begin
        chk("fwd o_a", o_a, a_drv);
        chk("fwd o_a_valid", o_av, av_drv);
        chk("fwd o_b", o_b, b_drv);
        chk("fwd o_b_valid", o_bv, bv_drv);
        chk("fwd o_start", o_st, st_drv);
      end
      if (o_cv) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected o_c_valid: got 1 want 0 (o_c=%0d cyc=%0d)", o_c, cyc);
        end else begin
          e = sb.pop_front();
          chk("o_c", o_c, e.c);
          chk("o_sat", o_sat, e.sat);
          chk("result cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    rst_drv = 1'b0;
    av_drv  = 1'b0;
    bv_drv  = 1'b0;
    a_drv   = '0;
    b_drv   = '0;
    st_drv  = 1'b0;
    k_drv   = '0;
    sh_drv  = '0;

    //            k  sh  n   a0  da  b0   db  c       s
    tbl[0]  = '{  4, 0,  4,  1,  1,  5,   1,  70,     0};
    tbl[1]  = '{  4, 0,  4,  1,  0,  2,   0,  8,      0};
    tbl[2]  = '{  1, 1,  1,  3,  0,  1,   0,  2,      0};
    tbl[3]  = '{  1, 1,  1, -3,  0,  1,   0, -1,      0};
    tbl[4]  = '{  1, 2,  1,  5,  0,  1,   0,  1,      0};
    tbl[5]  = '{ 16, 0, 16, -128, 0, -128, 0,  32767,  1};
    tbl[6]  = '{ 16, 0, 16, -128, 0, 127,  0, -32768,  1};
    tbl[7]  = '{  0, 0,  1,  7,  0, -3,   0, -21,     0};
    tbl[8]  = '{ 20, 4, 16, 10,  0, 10,   0,  100,    0};
    tbl[9]  = '{  3, 3,  3, -1, -1,  1,   0, -1,      0};
    tbl[10] = '{  2, 0,  2, 127, 0, 127,  0,  32258,  0};

    rst_next = 1'b0;
    idle(2);
    rst_next = 1'b1;
    idle(1);

    // Table vectors, applied back to back with no bubble between products.
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        beat(1'b1, 1'b1, tbl[i].a0 + j * tbl[i].da, tbl[i].b0 + j * tbl[i].db, (j == 0),
             tbl[i].k, tbl[i].sh);
        if (j == tbl[i].n - 1) expect_now(tbl[i].c, tbl[i].s);
      end
    end
    idle(2);
    chk("no err after clean traffic", o_err, 0);

    // Start while accumulating: partial discarded, new product from this beat.
    beat(1'b1, 1'b1, 1, 1, 1'b1, 4, 0);
    beat(1'b1, 1'b1, 1, 1, 1'b0, 4, 0);
    beat(1'b1, 1'b1, 2, 3, 1'b1, 4, 0);
    for (int j = 0; j < 3; j++) begin
      beat(1'b1, 1'b1, 1, 1, 1'b0, 4, 0);
    end
    expect_now(9, 1'b0);
    idle(2);
    chk("err start in acc", o_err, 1);

    // Reset during beat 2 discards the partial product and clears the error.
    beat(1'b1, 1'b1, 3, 3, 1'b1, 4, 0);
    rst_next = 1'b0;
    beat(1'b1, 1'b1, 3, 3, 1'b0, 4, 0);
    rst_next = 1'b1;
    idle(2);
    chk("err cleared by reset", o_err, 0);
    for (int j = 0; j < 4; j++) begin
      beat(1'b1, 1'b1, j + 1, j + 5, (j == 0), 4, 0);
    end
    expect_now(70, 1'b0);
    idle(1);

    // Stalls and an unqualified start leave the accumulation and o_c untouched.
    beat(1'b1, 1'b1, 3, 4, 1'b1, 2, 0);
    beat(1'b0, 1'b0, 0, 0, 1'b1, 2, 0);
    @(posedge clk);
    #1;
    chk("o_c holds in stall", o_c, 70);
    chk("no valid in stall", o_cv, 0);
    beat(1'b0, 1'b0, 9, 9, 1'b0, 2, 0);
    beat(1'b1, 1'b1, 1, 2, 1'b0, 2, 0);
    expect_now(14, 1'b0);
    idle(2);
    chk("no err on stall/unfired start", o_err, 0);

    // Single-sided valids flag an error and do not accumulate.
    beat(1'b1, 1'b1, 1, 1, 1'b1, 4, 0);
    beat(1'b1, 1'b0, 50, 0, 1'b0, 4, 0);
    beat(1'b0, 1'b1, 0, 50, 1'b0, 4, 0);
    for (int j = 0; j < 3; j++) begin
      beat(1'b1, 1'b1, 1, 1, 1'b0, 4, 0);
    end
    expect_now(4, 1'b0);
    idle(2);
    chk("err single valid", o_err, 1);

    idle(3);
    chk("all results seen", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_mac_rs.md
Name: pe_mac_rs

Overview:
- Next-generation systolic processing element for the matrix-multiply array.
- Performs a valid-qualified signed MAC over a runtime-programmable dot-product length.
- Forwards operands right (a) and down (b) with one-cycle latency.
- Emits a rounded, saturated, runtime-shifted result with a one-cycle valid pulse.
- Replaces hardcoded output slicing and reset-propagated framing with explicit start/valid framing.

Parameters:
- I_BITS, 8: signed operand width.
- K_MAX, 16: maximum dot-product length.
- O_BITS, 16: signed result width.
- ACC_BITS, 2*I_BITS+$clog2(K_MAX): accumulator width. Derived; do not override.
- K_BITS, $clog2(K_MAX+1): width of the length input.
- SHIFT_BITS, $clog2(ACC_BITS): width of the shift input.

Ports:
- i_clock  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_k_len  in  K_BITS  dot-product length; sampled at start of a dot product.
- i_shift  in  SHIFT_BITS  output right-shift; sampled at start of a dot product.
- i_a  in  I_BITS  signed operand from the left.
- i_a_valid  in  1  i_a valid.
- i_b  in  I_BITS  signed operand from above.
- i_b_valid  in  1  i_b valid.
- i_start  in  1  marks the first beat of a new dot product; qualified by fire.
- o_a, o_a_valid  out  I_BITS, 1  registered forward of i_a / i_a_valid.
- o_b, o_b_valid  out  I_BITS, 1  registered forward of i_b / i_b_valid.
- o_start  out  1  registered forward of i_start.
- o_c  out  O_BITS  signed result; holds until the next result.
- o_c_valid  out  1  one-cycle result pulse.
- o_sat  out  1  result was saturated; valid with o_c_valid.
- o_err  out  1  sticky framing error.

Behaviour:
- Reset: i_reset==0 at a posedge clears every register. All outputs read 0 the following cycle. Any partial dot product is discarded and no o_c_valid is produced.
- Forwarding: every cycle, o_a<=i_a, o_a_valid<=i_a_valid, o_b<=i_b, o_b_valid<=i_b_valid, o_start<=i_start. Forwarding is unconditional.
- Fire: fire = i_a_valid & i_b_valid. prod = i_a*i_b, full 2*I_BITS signed, sign-extended to ACC_BITS.
- Accumulation: states IDLE (count==0) and ACC (count>0).
  - Fire while in IDLE, or fire with i_start:
    - acc<=prod, count<=1.
    - Latch k_len = clamp(i_k_len, 1..K_MAX); 0 is treated as 1.
    - Latch shift = i_shift.
  - Fire in ACC without i_start: acc<=acc+prod, count<=count+1.
  - Fire when count_next==k_len (including k_len==1 on the start beat):
    - Next cycle: o_c<=round_sat(acc_next), o_c_valid=1.
    - count<=0, state returns to IDLE.
  - Result latency: o_c_valid asserts exactly 1 cycle after the last accepted beat.
- Back-to-back: a start beat on the cycle immediately after the last beat is legal. No bubble is required.
- Round/saturate:
  - s==0: y=acc.
  - s>0: y=(acc + 2^(s-1)) >>> s, computed in ACC_BITS+1 bits. This is round-half-up.
  - y > 2^(O_BITS-1)-1 gives max; y < -2^(O_BITS-1) gives min. In either case o_sat=1 alongside o_c_valid; otherwise o_sat=0.
- Framing errors (o_err sticky until reset):
  - Exactly one of i_a_valid/i_b_valid high: o_err<=1; no MAC, state unchanged.
  - i_start fires while in ACC: o_err<=1; partial result discarded; new dot product begins with this beat.
  - i_start without fire: ignored.
- Stalls: cycles without fire leave acc, count and o_c unchanged; o_c_valid=0.
- Width: ACC_BITS guarantees no accumulator overflow for K_MAX beats of the extreme products.

Decomposition:
- Shared package pe_pkg holds:
  - function acc_bits(I_BITS, K_MAX);
  - function round_shift_sat(acc, shift), parametrised by ACC_BITS/O_BITS, returning {sat, y};
  - localparams for the signed min/max of O_BITS.
- One sub-module: pe_round_sat, a combinational round-shift-saturate stage instantiated in front of the o_c register. It is reused later by the array drain/FIFO path.

Test Plan (I_BITS=8, K_MAX=16, O_BITS=16):
1. k_len=4, shift=0, start on beat 1; a={1,2,3,4}, b={5,6,7,8} on consecutive beats -> o_c=70, o_c_valid one cycle after beat 4, o_sat=0.
2. k_len=1, shift=1: a=3,b=1 -> o_c=2. Next: a=-3,b=1 -> o_c=-1. Next: a=5,b=1,shift=2 -> o_c=1.
3. k_len=16, shift=0, a=b=-128 on all beats -> acc=262144, o_c=32767, o_sat=1. Repeat with a=-128, b=127 -> o_c=-32768, o_sat=1.
4. k_len=4, two dot products with no gap; second uses a={1,1,1,1}, b={2,2,2,2} -> o_c=70 then o_c=8, each a single-cycle pulse. Forwarded o_a/o_b match inputs delayed by 1 cycle.
5. k_len=4, two beats fired, then i_start with a=2,b=3 and three more beats of 1*1 -> o_err=1, o_c=9. Separately, i_a_valid=1 with i_b_valid=0 -> o_err=1 and no accumulation.
6. i_reset=0 during beat 2 of a k_len=4 product -> all outputs 0 next cycle, no o_c_valid. After release, a fresh 4-beat product returns the correct sum.
